commit_trace_tx: RTL and testbench
==================================

// Module: commit_trace_tx
// PURPOSE
//  Transmit side of the retirement-check interface. Captures one record per retired instruction:
//   pc, instr, R/I/J class, register write-back.
//  Buffers records in a small FIFO and sends them on a valid/ready stream to the lockstep checker.
//  Sits beside the single-cycle core: core retire signals in, checker consumer out.
// PARAMETERS
//  DEPTH   8   FIFO entries; power of two, >= 2
//  SEQ_W   16  width of per-record sequence number
// PORTS
//  clk             in   1      core clock; all logic on rising edge
//  reset_n         in   1      synchronous, active-low reset
//  retire_valid    in   1      one instruction retires this cycle
//  retire_pc       in   32     pc of retiring instruction
//  retire_instr    in   32     instruction word
//  retire_class    in   2      trace_class_e (R/I/J/NONE)
//  retire_wr_en    in   1      instruction writes register file
//  retire_wr_reg   in   5      destination register
//  retire_wr_data  in   32     write-back value
//  retire_v0       in   32     current $v0 ($2) value (halt detect only)
//  stall_req       out  1      FIFO full; core must hold retirement
//  trace_valid     out  1      head record available
//  trace_ready     in   1      checker accepts head record
//  trace_rec       out  $bits(trace_rec_t)  head record: pc, instr, class, wr_en, wr_reg, wr_data, seq, halt
//  overflow        out  1      sticky: a record was dropped
// BEHAVIOUR
//  - Reset (reset_n==0 at edge): FIFO emptied, seq=0, overflow=0, halted=0.
//    Next cycle: trace_valid=0, stall_req=0, trace_rec=0. Reset mid-stream discards all buffered records.
//  - Push = retire_valid && !halted && (!full || pop), where pop = trace_valid && trace_ready.
//  - Full with simultaneous pop: push accepted, occupancy unchanged.
//  - retire_valid while full and no pop: record dropped, overflow set (sticky until reset).
//  - seq increments by 1 (mod 2^SEQ_W, 0xFFFF->0) on every retire_valid while !halted, accepted or dropped.
//    A drop is therefore visible to the checker as a seq gap.
//  - Record written at push:
//    - wr_en = retire_wr_en && (retire_wr_reg != 0); wr_reg and wr_data zeroed when wr_en==0.
//    - seq = value before increment; first record after reset has seq 0.
//  - Latency: record pushed at edge N is on trace_rec with trace_valid=1 from edge N (one cycle after retire).
//  - trace_rec is stable while trace_valid && !trace_ready.
//  - Empty with simultaneous push and pop: pop not possible (trace_valid=0). No bypass.
//  - stall_req = full (registered occupancy == DEPTH); it does not anticipate a same-cycle pop.
//  - Pointers wrap modulo DEPTH; occupancy counter has log2(DEPTH)+1 bits.
// CONFIGURATION
//  TRACE_HALT_DETECT_EN defined:
//   - A pushed record with instr==SYSCALL_INSTR (32'h0000_000C) and retire_v0==EXIT_V0 (32'hA) gets halt=1.
//   - halted is set at that edge. Later retire_valid is ignored: no push, no overflow, no seq change.
//   - Buffered records still drain normally.
//   - If that record is dropped (full), halted is still set.
//  Not defined: halt bit always 0, halted never set, retire_v0 ignored (port retained).
// STRUCTURE
//  Package mips_trace_pkg:
//   - trace_class_e: CLS_R=0, CLS_I=1, CLS_J=2, CLS_NONE=3
//   - trace_rec_t packed struct
//   - SYSCALL_INSTR, EXIT_V0 constants
//  Sub-module trace_fifo #(WIDTH, DEPTH):
//   - Generic sync FIFO with push/pop, full/empty, active-low sync reset.
//   - Head read combinationally from registered storage.
//  Top: seq counter, record formatting, drop/overflow logic, halt logic.
// TESTING
//  1 Reset, then retire pc=0x0, addi $2,$0,5 with trace_ready=1
//    -> next cycle trace_valid=1: seq=0, class=CLS_I, wr_reg=2, wr_data=5.
//  2 trace_ready=0, retire 8 consecutive
//    -> stall_req=1 after the 8th; 9th retire_valid dropped; overflow=1; next accepted record seq=9.
//  3 Full FIFO, trace_ready=1 and retire_valid=1 in the same cycle
//    -> push accepted, occupancy stays 8, order preserved.
//  4 Retire with wr_en=1, wr_reg=0, wr_data=0x1234
//    -> record wr_en=0, wr_reg=0, wr_data=0.
//  5 (TRACE_HALT_DETECT_EN) retire instr=0xC, v0=0xA, then 3 more retires
//    -> one record with halt=1, no further records, seq frozen, overflow=0.
//  6 Assert reset_n=0 with 5 buffered records
//    -> next cycle trace_valid=0; the record after release has seq=0.

Source files
------------

// File: rtl/mips_trace_pkg.sv
// Shared types and constants for the retirement trace stream.
package mips_trace_pkg;

   localparam int unsigned TRACE_SEQ_W = 16;

   localparam logic [31:0] SYSCALL_INSTR = 32'h0000_000C;
   localparam logic [31:0] EXIT_V0       = 32'h0000_000A;

   typedef enum logic [1:0] {
      CLS_R    = 2'd0,
      CLS_I    = 2'd1,
      CLS_J    = 2'd2,
      CLS_NONE = 2'd3
   } trace_class_e;

   typedef struct packed {
      logic [31:0]            pc;
      logic [31:0]            instr;
      trace_class_e           cls;
      logic                   wr_en;
      logic [4:0]             wr_reg;
      logic [31:0]            wr_data;
      logic [TRACE_SEQ_W-1:0] seq;
      logic                   halt;
   } trace_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// Generic synchronous FIFO; head is read combinationally from registered storage.
module trace_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;

   // Storage is cleared on reset so the head reads as zero until the first push.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign rd_data = mem[rd_ptr];
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);

endmodule

// File: rtl/commit_trace_tx.sv
// Retirement trace transmitter: formats one record per retired instruction and streams it out.
// Optional halt detection is enabled by defining TRACE_HALT_DETECT_EN.
module commit_trace_tx
   import mips_trace_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned SEQ_W = 16
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          retire_valid,
   input  logic [31:0]                   retire_pc,
   input  logic [31:0]                   retire_instr,
   input  logic [1:0]                    retire_class,
   input  logic                          retire_wr_en,
   input  logic [4:0]                    retire_wr_reg,
   input  logic [31:0]                   retire_wr_data,
   input  logic [31:0]                   retire_v0,
   output logic                          stall_req,
   output logic                          trace_valid,
   input  logic                          trace_ready,
   output logic [$bits(trace_rec_t)-1:0] trace_rec,
   output logic                          overflow
);

   logic             pop;
   logic             active;
   logic             push;
   logic             drop;
   logic             full;
   logic             empty;
   logic             halted;
   logic             halt_hit;
   logic [SEQ_W-1:0] seq_q;
   trace_rec_t       rec_in;

   assign trace_valid = !empty;
   assign stall_req   = full;
   assign pop         = trace_valid && trace_ready;
   assign active      = retire_valid && !halted;
   assign push        = active && (!full || pop);
   assign drop        = active && full && !pop;

   // Record formatting; write-back fields are zeroed for writes to $0 or no write.
   always_comb begin
      rec_in       = '0;
      rec_in.pc    = retire_pc;
      rec_in.instr = retire_instr;
      rec_in.cls   = trace_class_e'(retire_class);
      rec_in.wr_en = retire_wr_en && (retire_wr_reg != 5'd0);
      if (rec_in.wr_en) begin
         rec_in.wr_reg  = retire_wr_reg;
         rec_in.wr_data = retire_wr_data;
      end
      rec_in.seq  = TRACE_SEQ_W'(seq_q);
      rec_in.halt = halt_hit;
   end

   // Sequence advances on every live retire, so drops show up as seq gaps.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         seq_q    <= '0;
         overflow <= 1'b0;
      end else begin
         if (active) seq_q <= seq_q + SEQ_W'(1);
         if (drop) overflow <= 1'b1;
      end
   end

`ifdef TRACE_HALT_DETECT_EN
   assign halt_hit = (retire_instr == SYSCALL_INSTR) && (retire_v0 == EXIT_V0);

   // Halt latches even when the exit record itself is dropped.
   always_ff @(posedge clk) begin
      if (!reset_n) halted <= 1'b0;
      else if (active && halt_hit) halted <= 1'b1;
   end
`else
   logic unused_v0;
   assign halt_hit  = 1'b0;
   assign halted    = 1'b0;
   assign unused_v0 = ^retire_v0;
`endif

   trace_fifo #(
      .WIDTH ($bits(trace_rec_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .pop     (pop),
      .wr_data (rec_in),
      .rd_data (trace_rec),
      .full    (full),
      .empty   (empty)
   );

endmodule

// File: tb/tb_commit_trace_tx.sv
// Self-checking bench for commit_trace_tx: queue-based reference model plus directed literal checks.
module tb_commit_trace_tx;
   import mips_trace_pkg::*;

   localparam int unsigned DEPTH = 8;
`ifdef TRACE_HALT_DETECT_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic        retire_valid;
   logic [31:0] retire_pc;
   logic [31:0] retire_instr;
   logic [1:0]  retire_class;
   logic        retire_wr_en;
   logic [4:0]  retire_wr_reg;
   logic [31:0] retire_wr_data;
   logic [31:0] retire_v0;
   logic        stall_req;
   logic        trace_valid;
   logic        trace_ready;
   trace_rec_t  rec_out;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   commit_trace_tx #(.DEPTH(DEPTH), .SEQ_W(16)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .retire_valid   (retire_valid),
      .retire_pc      (retire_pc),
      .retire_instr   (retire_instr),
      .retire_class   (retire_class),
      .retire_wr_en   (retire_wr_en),
      .retire_wr_reg  (retire_wr_reg),
      .retire_wr_data (retire_wr_data),
      .retire_v0      (retire_v0),
      .stall_req      (stall_req),
      .trace_valid    (trace_valid),
      .trace_ready    (trace_ready),
      .trace_rec      (rec_out),
      .overflow       (overflow)
   );

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: a queue of expected records plus seq/overflow/halt state.
   trace_rec_t m_q[$];
   logic [15:0] m_seq;
   bit m_ovf, m_halted, m_zero, m_live = 1'b0;
   bit m_pop, m_acc;
   trace_rec_t m_r;

   task automatic model_edge();
      if (!reset_n) begin
         m_q.delete();
         m_seq = 16'd0; m_ovf = 1'b0; m_halted = 1'b0; m_zero = 1'b1; m_live = 1'b1;
      end else if (m_live) begin
         m_pop = (m_q.size() != 0) && trace_ready;
         m_acc = 1'b0;
         if (retire_valid && !m_halted) begin
            m_r = '0;
            m_r.pc    = retire_pc;
            m_r.instr = retire_instr;
            m_r.cls   = trace_class_e'(retire_class);
            m_r.wr_en = retire_wr_en && (retire_wr_reg != 0);
            if (m_r.wr_en) begin
               m_r.wr_reg  = retire_wr_reg;
               m_r.wr_data = retire_wr_data;
            end
            m_r.seq  = m_seq;
            m_r.halt = HALT_EN && (retire_instr == 32'hC) && (retire_v0 == 32'hA);
            if (m_q.size() < DEPTH || m_pop) m_acc = 1'b1;
            else m_ovf = 1'b1;
            if (m_r.halt) m_halted = 1'b1;
            m_seq = m_seq + 16'd1;
         end
         if (m_pop) void'(m_q.pop_front());
         if (m_acc) begin
            m_q.push_back(m_r);
            m_zero = 1'b0;
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_edge();
   end

   // Per-cycle comparison against the model, sampled away from the active edge.
   initial forever begin
      @(negedge clk);
      if (m_live) begin
         chk("trace_valid", 128'(trace_valid), 128'(m_q.size() != 0));
         chk("stall_req", 128'(stall_req), 128'(m_q.size() == DEPTH));
         chk("overflow", 128'(overflow), 128'(m_ovf));
         if (m_q.size() != 0) chk("trace_rec", 128'(rec_out), 128'(m_q[0]));
         else if (m_zero) chk("trace_rec_zero", 128'(rec_out), 128'd0);
      end
   end

   task automatic retire(input logic [31:0] pc, input logic [31:0] instr, input logic [1:0] cls,
                         input logic wen, input logic [4:0] wreg, input logic [31:0] wdata,
                         input logic [31:0] v0);
      retire_valid = 1'b1; retire_pc = pc; retire_instr = instr; retire_class = cls;
      retire_wr_en = wen; retire_wr_reg = wreg; retire_wr_data = wdata; retire_v0 = v0;
   endtask

   task automatic idle();
      retire_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0; idle();
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0; trace_ready = 1'b0;
      retire_valid = 1'b0; retire_pc = '0; retire_instr = '0; retire_class = '0;
      retire_wr_en = 1'b0; retire_wr_reg = '0; retire_wr_data = '0; retire_v0 = '0;
      @(negedge clk);
      @(negedge clk);
      chk("reset_valid", 128'(trace_valid), 128'd0);
      chk("reset_rec", 128'(rec_out), 128'd0);
      reset_n = 1'b1;

      // addi $2,$0,5 with the checker ready
      trace_ready = 1'b1;
      retire(32'h0, 32'h2002_0005, CLS_I, 1'b1, 5'd2, 32'd5, 32'd0);
      @(negedge clk); idle();
      chk("t1_valid", 128'(trace_valid), 128'd1);
      chk("t1_seq", 128'(rec_out.seq), 128'd0);
      chk("t1_cls", 128'(rec_out.cls), 128'(CLS_I));
      chk("t1_wr_reg", 128'(rec_out.wr_reg), 128'd2);
      chk("t1_wr_data", 128'(rec_out.wr_data), 128'd5);
      @(negedge clk);
      chk("t1_drained", 128'(trace_valid), 128'd0);

      // Fill with checker stalled, then drop one
      do_reset();
      trace_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         retire(32'h100 + 32'(4 * i), 32'h0085_1020, CLS_R, 1'b1, 5'd2, 32'(i * 3), 32'd0);
         @(negedge clk);
      end
      chk("t2_stall", 128'(stall_req), 128'd1);
      retire(32'h120, 32'h0085_1020, CLS_R, 1'b1, 5'd2, 32'h99, 32'd0);
      @(negedge clk);
      chk("t2_overflow", 128'(overflow), 128'd1);

      // Full with simultaneous pop and push
      trace_ready = 1'b1;
      retire(32'h124, 32'h0800_0040, CLS_J, 1'b0, 5'd0, 32'd0, 32'd0);
      @(negedge clk); idle();
      chk("t3_stall", 128'(stall_req), 128'd1);
      chk("t3_head_seq", 128'(rec_out.seq), 128'd1);
      for (int i = 0; i < 7; i++) @(negedge clk);
      chk("t3_gap_seq", 128'(rec_out.seq), 128'd9);
      @(negedge clk);
      chk("t3_empty", 128'(trace_valid), 128'd0);

      // Write to $0 is suppressed
      trace_ready = 1'b0;
      retire(32'h200, 32'h2000_1234, CLS_I, 1'b1, 5'd0, 32'h1234, 32'd0);
      @(negedge clk); idle();
      chk("t4_wr_en", 128'(rec_out.wr_en), 128'd0);
      chk("t4_wr_reg", 128'(rec_out.wr_reg), 128'd0);
      chk("t4_wr_data", 128'(rec_out.wr_data), 128'd0);
      chk("t4_sticky_ovf", 128'(overflow), 128'd1);
      trace_ready = 1'b1;
      @(negedge clk);

      // Mixed classes with intermittent back-pressure
      for (int i = 0; i < 16; i++) begin
         trace_ready = (i % 3) != 0;
         retire(32'h300 + 32'(4 * i), 32'h1000 + 32'(i), 2'(i), 1'(i % 2), 5'(i), 32'hA000 + 32'(i), 32'd0);
         @(negedge clk);
      end
      idle(); trace_ready = 1'b1;
      for (int i = 0; i < 10; i++) @(negedge clk);

      // Reset mid-stream with buffered records
      do_reset();
      trace_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         retire(32'h400 + 32'(4 * i), 32'h0000_0020, CLS_R, 1'b1, 5'd3, 32'(i), 32'd0);
         @(negedge clk);
      end
      reset_n = 1'b0; idle();
      @(negedge clk);
      chk("t6_valid", 128'(trace_valid), 128'd0);
      chk("t6_overflow", 128'(overflow), 128'd0);
      reset_n = 1'b1;
      retire(32'h500, 32'h2003_0001, CLS_I, 1'b1, 5'd3, 32'd1, 32'd0);
      @(negedge clk); idle();
      chk("t6_seq", 128'(rec_out.seq), 128'd0);

      // Exit syscall followed by further retires
      do_reset();
      trace_ready = 1'b0;
      retire(32'h600, 32'h0000_000C, CLS_R, 1'b0, 5'd0, 32'd0, 32'hA);
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         retire(32'h604 + 32'(4 * i), 32'h2004_0007, CLS_I, 1'b1, 5'd4, 32'd7, 32'hA);
         @(negedge clk);
      end
      idle();
`ifdef TRACE_HALT_DETECT_EN
      chk("t5_halt", 128'(rec_out.halt), 128'd1);
      chk("t5_stall", 128'(stall_req), 128'd0);
      chk("t5_overflow", 128'(overflow), 128'd0);
`else
      chk("t5_no_halt", 128'(rec_out.halt), 128'd0);
`endif
      trace_ready = 1'b1;
      @(negedge clk);
`ifdef TRACE_HALT_DETECT_EN
      chk("t5_no_more", 128'(trace_valid), 128'd0);
`endif
      for (int i = 0; i < 10; i++) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
